// File: rtl/present_sbox_serializer_pkg.sv
// Shared types and constants for the nibble-serial PRESENT S-box controller.
package present_sbox_serializer_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SHARES   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/present_sbox_serializer_if.sv
// Bundle of the request/result bus and the S-box side channel of the serializer.
// The slave side is the serializer; the master side is its environment
// (state producer/consumer plus the pipelined S-box itself).
interface present_sbox_serializer_if #(
    parameter int NIBBLES = 16
);
    import present_sbox_serializer_pkg::*;

    localparam int STATE_W = NIBBLE_W * NIBBLES;

    logic                start_i;
    logic [STATE_W-1:0]  state1_i;
    logic [STATE_W-1:0]  state2_i;
    logic [STATE_W-1:0]  state3_i;
    logic [NIBBLE_W-1:0] sb_in1_o;
    logic [NIBBLE_W-1:0] sb_in2_o;
    logic [NIBBLE_W-1:0] sb_in3_o;
    logic [NIBBLE_W-1:0] sb_out1_i;
    logic [NIBBLE_W-1:0] sb_out2_i;
    logic [NIBBLE_W-1:0] sb_out3_i;
    logic [STATE_W-1:0]  state1_o;
    logic [STATE_W-1:0]  state2_o;
    logic [STATE_W-1:0]  state3_o;
    logic                busy_o;
    logic                done_o;

    modport master (
        output start_i, state1_i, state2_i, state3_i,
        output sb_out1_i, sb_out2_i, sb_out3_i,
        input  sb_in1_o, sb_in2_o, sb_in3_o,
        input  state1_o, state2_o, state3_o,
        input  busy_o, done_o
    );

    modport slave (
        input  start_i, state1_i, state2_i, state3_i,
        input  sb_out1_i, sb_out2_i, sb_out3_i,
        output sb_in1_o, sb_in2_o, sb_in3_o,
        output state1_o, state2_o, state3_o,
        output busy_o, done_o
    );

endinterface

// File: rtl/present_nibble_shifter.sv
// One share's load/shift-right-by-4 register. The registered nibble output
// presents the least significant nibble first and is zeroed once the word is spent.
module present_nibble_shifter
    import present_sbox_serializer_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         load,
    input  logic                         shift,
    input  logic                         clear,
    input  logic [NIBBLE_W*NIBBLES-1:0]  data,
    output logic [NIBBLE_W-1:0]          nibble
);

    logic [NIBBLE_W*NIBBLES-1:0] sr;

    // Load presents nibble 0 at once and keeps the rest; each shift presents the next one.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sr     <= '0;
            nibble <= '0;
        end else if (load) begin
            nibble <= data[NIBBLE_W-1:0];
            sr     <= data >> NIBBLE_W;
        end else if (shift) begin
            nibble <= sr[NIBBLE_W-1:0];
            sr     <= sr >> NIBBLE_W;
        end else if (clear) begin
            nibble <= '0;
        end
    end

endmodule

// File: rtl/present_sbox_serializer.sv
// Nibble-serial controller around a 3-share pipelined PRESENT S-box: feeds one
// nibble per share per cycle, tracks the S-box latency with a valid pipeline,
// and reassembles the substituted shares. Shares are never combined.
module present_sbox_serializer
    import present_sbox_serializer_pkg::*;
#(
    parameter int LATENCY = 3,   // must be >= 1
    parameter int NIBBLES = 16
) (
    input logic                      clk,
    input logic                      rst_i,
    present_sbox_serializer_if.slave bus
);

    localparam int               STATE_W  = NIBBLE_W * NIBBLES;
    localparam int               CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    fsm_state_t          state;
    logic [CNT_W-1:0]    feed_cnt;
    logic [CNT_W-1:0]    cap_cnt;
    logic                in_valid;
    logic [LATENCY-1:0]  valid_pipe;
    logic                busy_q;
    logic                done_q;

    logic [STATE_W-1:0]  state_in [SHARES];
    logic [STATE_W-1:0]  acc_q    [SHARES];
    logic [STATE_W-1:0]  acc_next [SHARES];
    logic [STATE_W-1:0]  out_q    [SHARES];
    logic [NIBBLE_W-1:0] sb_in    [SHARES];
    logic [NIBBLE_W-1:0] sb_out   [SHARES];

    logic load, shift, clear, last_feed, capture, last_capture;

    assign state_in[0] = bus.state1_i;
    assign state_in[1] = bus.state2_i;
    assign state_in[2] = bus.state3_i;
    assign sb_out[0]   = bus.sb_out1_i;
    assign sb_out[1]   = bus.sb_out2_i;
    assign sb_out[2]   = bus.sb_out3_i;

    assign bus.sb_in1_o = sb_in[0];
    assign bus.sb_in2_o = sb_in[1];
    assign bus.sb_in3_o = sb_in[2];
    assign bus.state1_o = out_q[0];
    assign bus.state2_o = out_q[1];
    assign bus.state3_o = out_q[2];
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;

    assign load         = (state == IDLE) && bus.start_i;
    assign last_feed    = (state == FEED) && (feed_cnt == LAST_NIB);
    assign shift        = (state == FEED) && !last_feed;
    assign clear        = last_feed;
    assign capture      = valid_pipe[LATENCY-1];
    assign last_capture = capture && (cap_cnt == LAST_NIB);

    for (genvar s = 0; s < SHARES; s++) begin : g_share
        present_nibble_shifter #(.NIBBLES(NIBBLES)) u_shifter (
            .clk    (clk),
            .rst_i  (rst_i),
            .load   (load),
            .shift  (shift),
            .clear  (clear),
            .data   (state_in[s]),
            .nibble (sb_in[s])
        );
    end

    // Accumulator image with the nibble arriving this cycle merged in at the capture position.
    always_comb begin
        for (int s = 0; s < SHARES; s++) begin
            // NOTE: assign the full default first so every path drives acc_next and no latch appears.
            acc_next[s] = acc_q[s];
            acc_next[s][int'(cap_cnt) * NIBBLE_W +: NIBBLE_W] = sb_out[s];
        end
    end

    // Delay line marking which cycles carry a real S-box result.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    // Collect S-box results into the internal accumulators, one nibble per valid cycle.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cap_cnt <= '0;
            // NOTE: the accumulators are small flop banks, not RAM, so they take the async reset too.
            for (int s = 0; s < SHARES; s++) begin
                acc_q[s] <= '0;
            end
        end else if (capture) begin
            cap_cnt <= last_capture ? '0 : cap_cnt + 1'b1;
            for (int s = 0; s < SHARES; s++) begin
                acc_q[s] <= acc_next[s];
            end
        end
    end

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state    <= IDLE;
            feed_cnt <= '0;
            in_valid <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int s = 0; s < SHARES; s++) begin
                out_q[s] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state    <= FEED;
                        feed_cnt <= '0;
                        in_valid <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                FEED: begin
                    if (last_feed) begin
                        state    <= DRAIN;
                        in_valid <= 1'b0;
                    end else begin
                        feed_cnt <= feed_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_capture) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        for (int s = 0; s < SHARES; s++) begin
                            out_q[s] <= acc_next[s];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/present_sbox_serializer.md
Name: present_sbox_serializer

Overview:
- Nibble-serial controller for one PRESENT substitution layer on a 3-share masked 64-bit state.
- Sits directly upstream and downstream of the 3-share pipelined PRESENT S-box, and owns both sides of it.
- Slices the shared state into 16 nibbles and feeds one nibble per cycle into the S-box.
- Collects the S-box outputs after the pipeline latency, reassembles the substituted 3-share state, and signals completion.

Parameters:
- LATENCY, 3, clock cycles from a nibble appearing on sb_in*_o to its result appearing on sb_out*_i (must be >= 1).
- NIBBLES, 16, number of 4-bit S-box lanes per state word (state width = 4*NIBBLES).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request to process state*_i; accepted only in IDLE.
- state1_i  input  64  share 0 of the input state.
- state2_i  input  64  share 1 of the input state.
- state3_i  input  64  share 2 of the input state.
- sb_in1_o  output  4  share 0 nibble to the S-box.
- sb_in2_o  output  4  share 1 nibble to the S-box.
- sb_in3_o  output  4  share 2 nibble to the S-box.
- sb_out1_i  input  4  share 0 result from the S-box.
- sb_out2_i  input  4  share 1 result from the S-box.
- sb_out3_i  input  4  share 2 result from the S-box.
- state1_o  output  64  share 0 of the substituted state.
- state2_o  output  64  share 1 of the substituted state.
- state3_o  output  64  share 2 of the substituted state.
- busy_o  output  1  high from start acceptance until done.
- done_o  output  1  one-cycle pulse; state*_o is valid from this cycle on.

Behaviour:
- Reset (rst_i low, async): FSM goes to IDLE; feed/capture counters and valid pipeline are cleared; sb_in*_o, state*_o, busy_o and done_o are all 0. An operation in flight is abandoned, and no done_o is produced for it.
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE + start_i: latch state*_i into three internal shift registers; go to FEED; busy_o=1 from the next cycle.
  - FEED: each cycle, sb_in*_o (registered) presents nibble j = 0..NIBBLES-1, LSB nibble first (bits [4j+3:4j]), one per share. After j=NIBBLES-1, go to DRAIN.
  - DRAIN: sb_in*_o driven to 0 on all shares; wait until the last nibble has been captured, then go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o=0; return to IDLE.
- Timing: if start_i is sampled at edge k, nibble j is on sb_in*_o during cycle k+1+j.
- Capture: a LATENCY-deep valid shift register tracks presented nibbles. When the valid bit exits, sb_out*_i is written into nibble j of the result registers. The write position is a capture counter that increments 0..NIBBLES-1.
- Total latency: done_o asserts in cycle k+NIBBLES+LATENCY+1 (20 with defaults). state*_o updates in that same cycle.
- state*_o is written only at done. It holds its value until the next operation completes; intermediate captures go to internal registers, not the outputs.
- start_i while busy_o=1 or during DONE is ignored (no queueing). start_i held high through DONE re-triggers in the following IDLE cycle.
- Shares are never combined. No XOR across share indices anywhere in the block: each share path is an independent 4-bit slice/concatenate.
- Counters are sized $clog2(NIBBLES). The capture counter wraps to 0 at DONE.

Decomposition:
- Shared package: FSM state enum (IDLE/FEED/DRAIN/DONE), NIBBLE_W=4, SHARES=3.
- One natural sub-module: present_nibble_shifter.
  - Per-share load/shift-right-by-4 register feeding sb_in.
  - Instantiated three times, once per share.

Test Plan:
- Transparency:
  - Stimulus: bench S-box model = unmasked PRESENT table applied share-wise with LATENCY=3; state1_i=0x0123456789ABCDEF, state2_i=state3_i=0, start pulse at cycle 0.
  - Response: done_o at cycle 20; state1_o=0xC56B90AD3EF84712.
- Masked correctness:
  - Stimulus: random 3-share split of 0x0123456789ABCDEF with the real masked S-box, fresh randomness each cycle.
  - Response: the XOR of state1_o, state2_o and state3_o is 0xC56B90AD3EF84712.
- Ordering:
  - Stimulus: identity S-box model, state1_i=0xFEDCBA9876543210.
  - Response: sb_in1_o sequence 0,1,...,F in cycles 1..16; state1_o equals the input.
- Start while busy:
  - Stimulus: pulse start_i again at cycles 5 and 19 with a different state.
  - Response: single done at cycle 20 with the first result; second start ignored.
- Reset mid-operation:
  - Stimulus: rst_i low at cycle 8 for 2 cycles, then start at cycle 12.
  - Response: all outputs 0 during reset; no done before cycle 32; done at cycle 32 with the correct result.
- Back-to-back:
  - Stimulus: start_i held high continuously.
  - Response: done_o every 21 cycles; busy_o low only in the DONE cycle and the IDLE cycle.
